core_instr_prefetch_buffer: RTL and testbench
=============================================

// Module: core_instr_prefetch_buffer
// PURPOSE
//  Parametrised instruction-fetch front end: drives the naive_bus read channel and buffers fetched words
//  with their PCs in a DEPTH-entry FIFO. Sits between the instruction bus and the ID stage.
//  Adds valid/stall handshake, wait-state tolerance, redirect flush and in-flight response discard.
// PARAMETERS
//  DEPTH        4      FIFO entries; power of 2, >=2
//  BUBBLE_INSTR 32'h0  o_instr value while o_valid=0
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous active-low reset
//  i_boot_addr   in   32  reset fetch address; bits [1:0] ignored
//  i_stall       in   1   ID not accepting; holds head entry
//  i_bus_disable in   1   suppress new read requests
//  i_ex_jmp      in   1   EX redirect; highest priority
//  i_ex_target   in   32  EX redirect target
//  i_id_jmp      in   1   ID redirect
//  i_id_target   in   32  ID redirect target
//  o_pc          out  32  PC of head entry
//  o_instr       out  32  head instruction, BUBBLE_INSTR when invalid
//  o_valid       out  1   head entry valid
//  bus_master    naive_bus.master  rd_* driven; wr_req=0, wr_be=0, wr_addr=0, wr_data=0
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO count=0, inflight=0, fa={i_boot_addr[31:2],2'b00}; o_valid=0,
//    o_instr=BUBBLE_INSTR, o_pc=0.
//  - redir = i_ex_jmp|i_id_jmp; tgt = i_ex_jmp ? i_ex_target : i_id_target, bits [1:0] forced 0.
//  - rd_addr = redir ? tgt : fa (combinational). rd_be = {4{rd_req}}.
//  - rd_req = ~i_bus_disable & (redir | (count + inflight < DEPTH)). Compare at $clog2(DEPTH+1)+1 bits.
//  - Grant: rd_req&rd_gnt at cycle T -> rd_data valid at T+1. Set inflight<=1, rsp_pc<=rd_addr,
//    fa<=rd_addr+4 (32-bit wrap). Otherwise inflight<=0.
//  - Response at T+1 is pushed {rsp_pc, rd_data} into the FIFO unless redir in that cycle; then it is dropped.
//  - Wait states: rd_req&~rd_gnt -> fa unchanged, so rd_addr is held stable until granted.
//  - Redirect without grant: fa<=tgt.
//  - Pop: o_valid & ~i_stall. o_valid=(count!=0); head visible the cycle after its push (no bypass).
//  - Redirect: count<=0 (flush), regardless of pop/push that cycle. Target instr valid 2 cycles after
//    the granted redirect request.
//  - Simultaneous push+pop: count unchanged. Push when full cannot occur by the credit rule; assertion in sim.
//  - i_bus_disable: no new requests; an inflight response is still captured; fa holds.
//  - Reset mid-operation: all state returns to reset values; any pending bus response is ignored.
// CONFIGURATION
//  IFETCH_STATS_EN defined: adds out ports o_stat_fetch[31:0] (pushed words) and o_stat_flush[31:0]
//    (redirect cycles). Both are wrapping counters, reset 0.
//  Not defined: ports and counters are absent; fetch behaviour is identical.
// TESTING
//  1 boot=0x103, gnt=1 -> rd_addr 0x100,0x104,0x108 on consecutive cycles; o_valid at cycle 2, o_pc=0x100.
//  2 DEPTH=4, i_stall=1 -> rd_req drops once count+inflight=4; release -> pops 0x100..0x10C in order, then refills.
//  3 rd_gnt=0 for 3 cycles at 0x108 -> rd_addr stays 0x108; no push; on grant, data pushed with pc 0x108.
//  4 i_ex_jmp (tgt 0x400) and i_id_jmp (tgt 0x200) in same cycle as a response -> response dropped,
//    rd_addr=0x400, FIFO empty; 2 cycles later o_pc=0x400 valid.
//  5 i_bus_disable=1 with inflight=1 -> word pushed, rd_req=0, rd_be=0; deassert -> resumes at fa.
//  6 rst_n low mid-stream -> o_valid=0 immediately; after release, rd_addr=boot address.

Source files
------------

// File: rtl/core_instr_prefetch_buffer_if.sv
// naive_bus: simple request/grant memory bus. Read data returns the cycle after a granted read.
// Handshake: a read transfer happens in a cycle where rd_req & rd_gnt; rd_data is valid on the next cycle.
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_be, rd_addr,
        input  rd_gnt, rd_data,
        output wr_req, wr_be, wr_addr, wr_data
    );

    modport slave (
        input  rd_req, rd_be, rd_addr,
        output rd_gnt, rd_data,
        input  wr_req, wr_be, wr_addr, wr_data
    );
endinterface

// File: rtl/core_instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues naive_bus reads and queues {pc, instr} in a DEPTH-entry FIFO.
// Optional IFETCH_STATS_EN adds o_stat_fetch / o_stat_flush counters.
module core_instr_prefetch_buffer #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_boot_addr,
    input  logic        i_stall,
    input  logic        i_bus_disable,
    input  logic        i_ex_jmp,
    input  logic [31:0] i_ex_target,
    input  logic        i_id_jmp,
    input  logic [31:0] i_id_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid,
    naive_bus.master    bus_master
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] o_stat_fetch,
    output logic [31:0] o_stat_flush
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

    logic [31:0]   r_fa;
    logic          r_inflight;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];

    logic          w_redir;
    logic [31:0]   w_tgt;
    logic [CW-1:0] w_used;
    logic          w_credit;
    logic          w_rd_req;
    logic [31:0]   w_rd_addr;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;

    assign w_redir   = i_ex_jmp | i_id_jmp;
    assign w_tgt     = (i_ex_jmp ? i_ex_target : i_id_target) & 32'hFFFF_FFFC;

    // Credit: only request when the response is guaranteed a free FIFO slot, unless a redirect flushes it.
    assign w_used    = r_count + CW'(r_inflight);
    assign w_credit  = (w_used < CW'(DEPTH));
    assign w_rd_req  = ~i_bus_disable & (w_redir | w_credit);
    assign w_rd_addr = w_redir ? w_tgt : r_fa;
    assign w_grant   = w_rd_req & bus_master.rd_gnt;

    assign w_valid   = (r_count != '0);
    assign w_push    = r_inflight & ~w_redir;
    assign w_pop     = w_valid & ~i_stall;

    assign bus_master.rd_req  = w_rd_req;
    assign bus_master.rd_addr = w_rd_addr;
    assign bus_master.rd_be   = {4{w_rd_req}};
    assign bus_master.wr_req  = 1'b0;
    assign bus_master.wr_be   = 4'b0000;
    assign bus_master.wr_addr = 32'h0;
    assign bus_master.wr_data = 32'h0;

    assign o_valid = w_valid;
    assign o_instr = w_valid ? r_mem_instr[r_rd_ptr] : BUBBLE_INSTR;
    assign o_pc    = w_valid ? r_mem_pc[r_rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fa       <= i_boot_addr & 32'hFFFF_FFFC;
            r_inflight <= 1'b0;
            r_rsp_pc   <= 32'h0;
        end else begin
            r_inflight <= w_grant;
            if (w_grant) begin
                r_rsp_pc <= w_rd_addr;
                r_fa     <= w_rd_addr + 32'd4;
            end else if (w_redir) begin
                r_fa     <= w_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_redir) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
            r_mem_instr[r_wr_ptr] <= bus_master.rd_data;
        end
    end

`ifdef IFETCH_STATS_EN
    logic [31:0] r_stat_fetch;
    logic [31:0] r_stat_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_fetch <= 32'h0;
            r_stat_flush <= 32'h0;
        end else begin
            if (w_push) begin
                r_stat_fetch <= r_stat_fetch + 32'd1;
            end
            if (w_redir) begin
                r_stat_flush <= r_stat_flush + 32'd1;
            end
        end
    end

    assign o_stat_fetch = r_stat_fetch;
    assign o_stat_flush = r_stat_flush;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
        end
    end
`endif

endmodule

// File: tb/tb_core_instr_prefetch_buffer.sv
// Randomised bench for core_instr_prefetch_buffer against a queue-based reference model.
module tb_core_instr_prefetch_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_boot_addr;
    logic        i_stall;
    logic        i_bus_disable;
    logic        i_ex_jmp;
    logic [31:0] i_ex_target;
    logic        i_id_jmp;
    logic [31:0] i_id_target;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_valid;
`ifdef IFETCH_STATS_EN
    logic [31:0] o_stat_fetch;
    logic [31:0] o_stat_flush;
`endif

    naive_bus bus ();

    core_instr_prefetch_buffer #(
        .DEPTH        (DEPTH),
        .BUBBLE_INSTR (BUBBLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_boot_addr   (i_boot_addr),
        .i_stall       (i_stall),
        .i_bus_disable (i_bus_disable),
        .i_ex_jmp      (i_ex_jmp),
        .i_ex_target   (i_ex_target),
        .i_id_jmp      (i_id_jmp),
        .i_id_target   (i_id_target),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_valid       (o_valid),
        .bus_master    (bus.master)
`ifdef IFETCH_STATS_EN
        ,
        .o_stat_fetch  (o_stat_fetch),
        .o_stat_flush  (o_stat_flush)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_fa;
    logic        m_inflight;
    logic [31:0] m_rsp_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        return t;
    endfunction

    task automatic model_reset(input logic [31:0] boot);
        exp_pc_q.delete();
        exp_q.delete();
        m_fa       = boot & 32'hFFFF_FFFC;
        m_inflight = 1'b0;
        m_rsp_pc   = 32'h0;
        m_fetch    = 32'h0;
        m_flush    = 32'h0;
    endtask

    task automatic check_head();
        check("o_valid", {31'h0, o_valid}, {31'h0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("o_pc", o_pc, exp_pc_q[0]);
            check("o_instr", o_instr, exp_q[0]);
        end else begin
            check("o_instr_bubble", o_instr, BUBBLE);
        end
`ifdef IFETCH_STATS_EN
        check("stat_fetch", o_stat_fetch, m_fetch);
        check("stat_flush", o_stat_flush, m_flush);
`endif
    endtask

    // One cycle, entered and left at a falling edge. Percentages steer each input.
    task automatic step(input int stall_pct, input int jmp_pct, input int gnt_pct, input int dis_pct);
        logic        redir;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        pop;
        logic        push;
        check_head();
        i_stall       = ($urandom_range(0, 99) < stall_pct);
        i_bus_disable = ($urandom_range(0, 99) < dis_pct);
        i_ex_jmp      = ($urandom_range(0, 99) < jmp_pct);
        i_id_jmp      = ($urandom_range(0, 99) < jmp_pct);
        i_ex_target   = rand_target();
        i_id_target   = rand_target();
        bus.rd_gnt    = ($urandom_range(0, 99) < gnt_pct);
        bus.rd_data   = m_inflight ? mem_word(m_rsp_pc) : $urandom;
        #1;
        redir = i_ex_jmp | i_id_jmp;
        tgt   = (i_ex_jmp ? i_ex_target : i_id_target) & 32'hFFFF_FFFC;
        req   = !i_bus_disable && (redir || (exp_q.size() + int'(m_inflight) < DEPTH));
        addr  = redir ? tgt : m_fa;
        check("rd_req", {31'h0, bus.rd_req}, {31'h0, req});
        check("rd_addr", bus.rd_addr, addr);
        check("rd_be", {28'h0, bus.rd_be}, {28'h0, {4{req}}});
        check("wr_idle", {bus.wr_data | bus.wr_addr}, 32'h0);
        pop  = (exp_q.size() != 0) && !i_stall;
        push = m_inflight && !redir;
        if (push) m_fetch++;
        if (redir) m_flush++;
        if (redir) begin
            exp_q.delete();
            exp_pc_q.delete();
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (push) begin
                exp_q.push_back(bus.rd_data);
                exp_pc_q.push_back(m_rsp_pc);
            end
        end
        if (req && bus.rd_gnt) begin
            m_inflight = 1'b1;
            m_rsp_pc   = addr;
            m_fa       = addr + 32'd4;
        end else begin
            m_inflight = 1'b0;
            if (redir) m_fa = tgt;
        end
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        i_stall       = 1'b0;
        i_bus_disable = 1'b0;
        i_ex_jmp      = 1'b0;
        i_id_jmp      = 1'b0;
        i_ex_target   = 32'h0;
        i_id_target   = 32'h0;
        bus.rd_gnt    = 1'b1;
        bus.rd_data   = $urandom;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_n       = 1'b0;
        i_boot_addr = boot;
        quiet_inputs();
        #1;
        check("rst_o_valid", {31'h0, o_valid}, 32'h0);
        check("rst_o_instr", o_instr, BUBBLE);
        check("rst_o_pc", o_pc, 32'h0);
        check("rst_rd_addr", bus.rd_addr, boot & 32'hFFFF_FFFC);
        check("rst_rd_req", {31'h0, bus.rd_req}, 32'h1);
        model_reset(boot);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_boot_addr = 32'h0000_0103;
        quiet_inputs();
        @(negedge clk);
        do_reset(32'h0000_0103);
        // streaming from boot with an always-granting bus
        for (int i = 0; i < 12; i++) step(0, 0, 100, 0);
        // ID stalled: FIFO fills and requests stop, then drains
        for (int i = 0; i < 12; i++) step(100, 0, 100, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 100, 0);
        // wait states
        for (int i = 0; i < 40; i++) step(20, 0, 30, 0);
        // redirect-heavy traffic
        for (int i = 0; i < 200; i++) step(40, 25, 70, 5);
        // bus disable heavy
        for (int i = 0; i < 100; i++) step(30, 5, 80, 50);
        // reset mid-stream, new boot address
        for (int i = 0; i < 5; i++) step(60, 0, 100, 0);
        do_reset(32'h0000_2001);
        for (int i = 0; i < 6; i++) step(0, 0, 100, 0);
        // long mixed random run
        for (int i = 0; i < 1500; i++) step(35, 8, 75, 10);
        check_head();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
